// File: rtl/snoop_responder.sv
// Bus snoop responder: looks up a snooped address in the tag array, reports
// NOHIT/HIT/HITM, downgrades or invalidates the line and writes back dirty data.
module snoop_responder #(
    parameter int ADDR_BITS   = 32,
    parameter int INDEX_BITS  = 14,
    parameter int TAG_BITS    = 12,
    parameter int OFFSET_BITS = 6,
    parameter int WAY_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [1:0]            snp_op,
    input  logic [ADDR_BITS-1:0]  snp_addr,
    output logic                  lk_req,
    output logic [INDEX_BITS-1:0] lk_index,
    output logic [TAG_BITS-1:0]   lk_tag,
    input  logic                  lk_hit,
    input  logic [WAY_BITS-1:0]   lk_way,
    input  logic [1:0]            lk_mesi,
    output logic                  upd_en,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [WAY_BITS-1:0]   upd_way,
    output logic [1:0]            upd_mesi,
    output logic                  snp_result_valid,
    output logic [1:0]            snp_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_BITS-1:0]  wb_addr,
    output logic [15:0]           hitm_count
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, WB} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RWIM  = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam logic [1:0] RES_NOHIT = 2'b00;
    localparam logic [1:0] RES_HIT   = 2'b01;
    localparam logic [1:0] RES_HITM  = 2'b10;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [15:0]           hitm_count_q, hitm_count_d;
    logic [1:0]            cur_mesi;
    logic                  need_wb;

    // A miss is an invalid line no matter what the array reports for the state.
    assign cur_mesi = lk_hit ? lk_mesi : MESI_I;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        index_d          = index_q;
        tag_d            = tag_q;
        hitm_count_d     = hitm_count_q;
        snp_ready        = 1'b0;
        lk_req           = 1'b0;
        upd_en           = 1'b0;
        upd_mesi         = MESI_I;
        snp_result_valid = 1'b0;
        snp_result       = RES_NOHIT;
        wb_valid         = 1'b0;
        need_wb          = 1'b0;

        case (state_q)
            IDLE: begin
                snp_ready = 1'b1;
                if (snp_valid) begin
                    op_d    = snp_op;
                    index_d = snp_addr[OFFSET_BITS +: INDEX_BITS];
                    tag_d   = snp_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lk_req  = 1'b1;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                snp_result_valid = 1'b1;
                case (op_q)
                    OP_READ: begin
                        case (cur_mesi)
                            MESI_M: begin
                                snp_result = RES_HITM;
                                need_wb    = 1'b1;
                                upd_en     = 1'b1;
                                upd_mesi   = MESI_S;
                            end
                            MESI_E: begin
                                snp_result = RES_HIT;
                                upd_en     = 1'b1;
                                upd_mesi   = MESI_S;
                            end
                            MESI_S:  snp_result = RES_HIT;
                            default: snp_result = RES_NOHIT;
                        endcase
                    end
                    // INVALIDATE on a modified line is a protocol error; recover
                    // exactly like RWIM so the dirty data is not lost.
                    OP_RWIM, OP_INV: begin
                        case (cur_mesi)
                            MESI_M: begin
                                snp_result = RES_HITM;
                                need_wb    = 1'b1;
                                upd_en     = 1'b1;
                            end
                            MESI_E, MESI_S: begin
                                snp_result = RES_HIT;
                                upd_en     = 1'b1;
                            end
                            default: snp_result = RES_NOHIT;
                        endcase
                    end
                    OP_WRITE: snp_result = RES_NOHIT;
                    default:  snp_result = RES_NOHIT;
                endcase
                if (snp_result == RES_HITM && hitm_count_q != 16'hFFFF)
                    hitm_count_d = hitm_count_q + 16'd1;
                state_d = need_wb ? WB : IDLE;
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            index_q      <= '0;
            tag_q        <= '0;
            hitm_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            hitm_count_q <= hitm_count_d;
        end
    end

    assign lk_index   = index_q;
    assign lk_tag     = tag_q;
    assign upd_index  = index_q;
    assign upd_way    = lk_way;
    assign wb_addr    = ADDR_BITS'({tag_q, index_q, {OFFSET_BITS{1'b0}}});
    assign hitm_count = hitm_count_q;

endmodule
